// File: rtl/act_skew_feeder.sv
// Skews activation vectors into a systolic array: row r is delayed r+1 advancing cycles; stall freezes everything.
// Optional accept counter on stat_vec_count when ACT_SKEW_FEEDER_STATS_EN is defined (tied to 0 otherwise).
module act_skew_feeder #(
  parameter int ROWS            = 4,
  parameter int ACTIVATION_SIZE = 8
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ROWS*ACTIVATION_SIZE-1:0] in_vec,
  input  logic                            in_last,
  input  logic                            stall,
  output logic [ROWS*ACTIVATION_SIZE-1:0] out_vec,
  output logic [ROWS-1:0]                 out_valid,
  output logic                            tile_done,
  output logic [15:0]                     stat_vec_count
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS + 1) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state;
  logic [CW-1:0]   drain_cnt;
  logic [ROWS-1:0] last_q;
  logic            accept;
  logic            advance;

  assign advance  = !stall;
  assign in_ready = !stall && (state != DRAIN);
  assign accept   = in_valid && in_ready;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [ACTIVATION_SIZE-1:0] dat [0:r];
    logic [r:0]                 vld;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int s = 0; s <= r; s++) dat[s] <= '0;
        vld <= '0;
      end else if (advance) begin
        dat[0] <= accept ? in_vec[r*ACTIVATION_SIZE +: ACTIVATION_SIZE] : '0;
        vld[0] <= accept;
        for (int s = 1; s <= r; s++) begin
          dat[s] <= dat[s-1];
          vld[s] <= vld[s-1];
        end
      end
    end

    assign out_vec[r*ACTIVATION_SIZE +: ACTIVATION_SIZE] = dat[r];
    assign out_valid[r] = vld[r];
  end

  // The last flag rides alongside the longest (row ROWS-1) chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= '0;
    end else if (advance) begin
      last_q[0] <= accept && in_last;
      for (int s = 1; s < ROWS; s++) last_q[s] <= last_q[s-1];
    end
  end

  assign tile_done = last_q[ROWS-1] && out_valid[ROWS-1];

  // DRAIN blocks new input until the last vector has left row 0 for long enough
  // that the next tile cannot overlap it in any row.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else if (advance) begin
      if (accept) begin
        if (in_last) begin
          if (ROWS == 1) begin
            state     <= IDLE;
            drain_cnt <= '0;
          end else begin
            state     <= DRAIN;
            drain_cnt <= CW'(ROWS - 1);
          end
        end else begin
          state <= STREAM;
        end
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt - 1'b1;
        if (drain_cnt == CW'(1)) state <= IDLE;
      end
    end
  end

`ifdef ACT_SKEW_FEEDER_STATS_EN
  logic [15:0] vec_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vec_cnt <= '0;
    end else if (accept && (vec_cnt != 16'hFFFF)) begin
      vec_cnt <= vec_cnt + 16'd1;
    end
  end

  assign stat_vec_count = vec_cnt;
`else
  assign stat_vec_count = '0;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Randomized bench for act_skew_feeder against a history-based reference model.
module tb_act_skew_feeder;
  localparam int ROWS = 4;
  localparam int AS   = 8;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*AS-1:0]   in_vec;
  logic                 in_last;
  logic                 stall;
  logic [ROWS*AS-1:0]   out_vec;
  logic [ROWS-1:0]      out_valid;
  logic                 tile_done;
  logic [15:0]          stat_vec_count;

  act_skew_feeder #(.ROWS(ROWS), .ACTIVATION_SIZE(AS)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_last(in_last), .stall(stall), .out_vec(out_vec),
    .out_valid(out_valid), .tile_done(tile_done), .stat_vec_count(stat_vec_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: vectors accepted, keyed by the index of the advancing edge that took them.
  logic [ROWS*AS-1:0] acc_vec  [int];
  bit                 acc_last [int];
  int                 n_adv;
  int                 last_idx;
  int                 n_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    acc_vec.delete();
    acc_last.delete();
    n_adv    = 0;
    last_idx = -1000;
    n_acc    = 0;
  endtask

  function automatic logic exp_ready(input logic st);
    // Blocked while fewer than ROWS-1 advancing edges have followed the last tile end.
    return !st && !((n_adv - 1 - last_idx) < (ROWS - 1));
  endfunction

  function automatic logic [15:0] exp_stat();
`ifdef ACT_SKEW_FEEDER_STATS_EN
    return (n_acc > 65535) ? 16'hFFFF : 16'(n_acc);
`else
    return 16'h0;
`endif
  endfunction

  task automatic check_outputs();
    logic [ROWS*AS-1:0] v;
    int idx;
    bit has;
    for (int r = 0; r < ROWS; r++) begin
      idx = n_adv - 1 - r;
      has = acc_vec.exists(idx);
      v   = has ? acc_vec[idx] : '0;
      check($sformatf("out_vec[%0d]", r), 64'(out_vec[r*AS +: AS]), 64'(v[r*AS +: AS]));
      check($sformatf("out_valid[%0d]", r), 64'(out_valid[r]), 64'(has));
    end
    idx = n_adv - ROWS;
    check("tile_done", 64'(tile_done), 64'(acc_vec.exists(idx) && acc_last[idx]));
    check("stat_vec_count", 64'(stat_vec_count), 64'(exp_stat()));
  endtask

  // One clock: drive inputs, check ready, update model, clock, check outputs.
  task automatic step(input logic v, input logic lst, input logic st, input logic [ROWS*AS-1:0] vec);
    logic rdy;
    in_valid = v; in_last = lst; stall = st; in_vec = vec;
    #1;
    rdy = exp_ready(st);
    check("in_ready", 64'(in_ready), 64'(rdy));
    if (!st) begin
      if (v && rdy) begin
        acc_vec[n_adv]  = vec;
        acc_last[n_adv] = lst;
        if (lst) last_idx = n_adv;
        n_acc++;
      end
      n_adv++;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; stall = 1'b0; in_vec = '0;
    #2;
    resetn = 1'b0;
    #1;
    check("rst out_vec", 64'(out_vec), 64'h0);
    check("rst out_valid", 64'(out_valid), 64'h0);
    check("rst tile_done", 64'(tile_done), 64'h0);
    check("rst stat", 64'(stat_vec_count), 64'h0);
    check("rst in_ready", 64'(in_ready), 64'h1);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_last = 1'b0; stall = 1'b0; in_vec = '0;
    model_reset();
    #3;
    check("por out_valid", 64'(out_valid), 64'h0);
    check("por tile_done", 64'(tile_done), 64'h0);
    stall = 1'b1;
    #1;
    check("por in_ready stalled", 64'(in_ready), 64'h0);
    stall = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // Single vector tile {1,2,3,-4}
    step(1'b1, 1'b1, 1'b0, {8'hFC, 8'd3, 8'd2, 8'd1});
    idle(3);
    check("row3 value", 64'(out_vec[3*AS +: AS]), 64'hFC);
    check("row3 tile_done", 64'(tile_done), 64'h1);
    idle(2);

    // Three-vector tile streamed back to back
    step(1'b1, 1'b0, 1'b0, {8'h13, 8'h12, 8'h11, 8'h10});
    step(1'b1, 1'b0, 1'b0, {8'h23, 8'h22, 8'h21, 8'h20});
    step(1'b1, 1'b1, 1'b0, {8'h33, 8'h32, 8'h31, 8'h30});
    idle(6);

    // Stall held two cycles in DRAIN at count 2
    step(1'b1, 1'b1, 1'b0, {8'h80, 8'h7F, 8'h01, 8'hFF});
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    idle(5);

    // in_valid held high through DRAIN into the next tile
    step(1'b1, 1'b1, 1'b0, {8'hA3, 8'hA2, 8'hA1, 8'hA0});
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, {8'hB3, 8'hB2, 8'hB1, 8'hB0});
    idle(6);

    // Reset with two vectors in flight, then a repeat of the single-vector tile
    step(1'b1, 1'b0, 1'b0, {8'hC3, 8'hC2, 8'hC1, 8'hC0});
    step(1'b1, 1'b0, 1'b0, {8'hD3, 8'hD2, 8'hD1, 8'hD0});
    do_reset();
    idle(2);
    step(1'b1, 1'b1, 1'b0, {8'hFC, 8'd3, 8'd2, 8'd1});
    idle(5);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 2),
           1'($urandom_range(0, 9) < 2), $urandom);
    end
    idle(6);

`ifdef ACT_SKEW_FEEDER_STATS_EN
    for (int i = 0; i < 70000; i++) step(1'b1, 1'b0, 1'b0, $urandom);
    check("stat saturated", 64'(stat_vec_count), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 Parameter ROWS, default 4: array rows fed, range 1..64.
REQ-002 Parameter ACTIVATION_SIZE, default 8: signed activation width per row.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream offers one activation vector.
REQ-006 in_ready  output  1  feeder accepts vector this cycle.
REQ-007 in_vec  input  ROWS*ACTIVATION_SIZE  row r at bits [r*ACTIVATION_SIZE +: ACTIVATION_SIZE].
REQ-008 in_last  input  1  qualifies final vector of a tile.
REQ-009 stall  input  1  array freeze; no feeder state advances.
REQ-010 out_vec  output  ROWS*ACTIVATION_SIZE  skewed activations to array row inputs, same packing.
REQ-011 out_valid  output  ROWS  per-row valid for out_vec.
REQ-012 tile_done  output  1  final-stage row ROWS-1 holds tile's last element.
REQ-013 stat_vec_count  output  16  accepted-vector count (see Configuration).

Function
REQ-014 Accept = in_valid && in_ready; in_ready = !stall && state != DRAIN (combinational).
REQ-015 Row r is a (r+1)-stage register chain of {data, valid}; advances only when stall==0.
REQ-016 On advance, stage 0 of each row loads in_vec[r] with valid=1 if accept, else data=0, valid=0.
REQ-017 out_vec[r]/out_valid[r] = final stage of row r; row r latency r+1 advancing cycles after accept.
REQ-018 Data passes unmodified; no arithmetic, no sign extension, no truncation.
REQ-019 States IDLE, STREAM, DRAIN; IDLE->STREAM on accept with in_last=0.
REQ-020 Accept with in_last=1 (from IDLE or STREAM) -> DRAIN, drain counter loaded ROWS-1; when ROWS==1 -> IDLE instead.
REQ-021 In DRAIN counter decrements per advancing cycle; at count 1 decrementing to 0 -> IDLE.
REQ-022 A last flag travels with row ROWS-1 chain; tile_done = final-stage last flag && out_valid[ROWS-1].
REQ-023 stall==1: all chains, state, counter, tile_done, outputs hold; mid-drain stall extends DRAIN exactly by stall cycles.
REQ-024 Back-to-back tiles: next tile accepted first cycle after DRAIN->IDLE; no overlap of tiles in any row.
REQ-025 in_valid while in_ready==0: no state change, vector not consumed.

Reset
REQ-026 resetn low asynchronously clears all chain data and valid to 0, last flags to 0, counter to 0, state to IDLE.
REQ-027 During and after reset: out_vec=0, out_valid=0, tile_done=0, stat_vec_count=0, in_ready=!stall.
REQ-028 Reset mid-tile discards in-flight data; no tile_done emitted for that tile.

Configuration
REQ-029 Macro ACT_SKEW_FEEDER_STATS_EN: defined -> stat_vec_count increments by 1 per accept, saturates at 65535, unaffected by stall otherwise.
REQ-030 Undefined -> no counter logic; stat_vec_count tied to 0; all other behaviour identical.

Verification (ROWS=4, ACTIVATION_SIZE=8)
REQ-031 Single vector {r0=1,r1=2,r2=3,r3=-4}, in_last=1, stall=0 -> out_valid[0..3] pulse 1,2,3,4 cycles after accept with values 1,2,3,-4; tile_done with row 3; in_ready low 3 cycles.
REQ-032 Tile of 3 vectors streamed back-to-back -> each row outputs 3 consecutive valid beats, row r starting r+1 cycles after first accept; zeros with valid=0 elsewhere.
REQ-033 Stall held 2 cycles during DRAIN at count 2 -> outputs frozen, DRAIN lasts 5 cycles total, tile_done still aligned with final row-3 beat.
REQ-034 in_valid held high during DRAIN -> no accept until IDLE; next tile's first vector reaches row 0 one cycle after ready returns.
REQ-035 resetn asserted with 2 vectors in flight -> all outputs 0 immediately, no tile_done, next tile behaves as REQ-031.
REQ-036 STATS_EN defined, 70000 accepts -> stat_vec_count=65535; undefined -> stat_vec_count=0 throughout.
